// File: rtl/rgb_pwm_driver.sv
// rtl/rgb_pwm_driver.sv - NCH-channel PWM LED driver with static/blink/breathe modes.
// Optional square-law duty correction when RGB_GAMMA_EN is defined.
module rgb_pwm_driver #(
    parameter int NCH        = 3,
    parameter int PWM_W      = 8,
    parameter int PRESC      = 64,
    parameter int BLINK_LOG2 = 2,
    parameter int CNT_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [NCH*PWM_W-1:0]   duty_in,
    input  logic                   load,
    output logic [NCH-1:0]         led,
    output logic                   period_start
);

    localparam int PS_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [1:0] MODE_BLINK   = 2'd1;
    localparam logic [1:0] MODE_BREATHE = 2'd2;
    localparam logic ST_UP   = 1'b0;
    localparam logic ST_DOWN = 1'b1;
    localparam logic [PWM_W-1:0] PWM_MAX    = '1;
    localparam logic [PWM_W-1:0] ENV_TOP_M1 = PWM_MAX - PWM_W'(1);
    localparam logic [PWM_W-1:0] ENV_ONE    = PWM_W'(1);

    logic [CNT_W-1:0]       count;
    logic [PS_W-1:0]        presc;
    logic [PWM_W-1:0]       pwm_cnt;
    logic [PWM_W-1:0]       env;
    logic                   br_state;
    logic [BLINK_LOG2:0]    blink_cnt;
    logic [NCH*PWM_W-1:0]   shadow_duty;
    logic [NCH*PWM_W-1:0]   active_duty;
    logic [1:0]             shadow_mode;
    logic [1:0]             active_mode;
    logic                   pending;
    logic                   tick;
    logic                   boundary;
    logic                   apply;
    logic [1:0]             new_mode;
    logic                   blink_on;
    logic [NCH-1:0]         led_next;

    assign tick     = (presc == PS_W'(PRESC - 1));
    assign boundary = tick && (pwm_cnt == PWM_MAX);
    assign apply    = load || pending;
    // A load on the boundary cycle itself bypasses the shadow registers.
    assign new_mode = load ? mode : (pending ? shadow_mode : active_mode);
    assign blink_on = blink_cnt[BLINK_LOG2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            presc   <= '0;
            pwm_cnt <= '0;
        end else begin
            count <= count + CNT_W'(1);
            presc <= tick ? '0 : presc + PS_W'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_duty <= '0;
            shadow_mode <= '0;
            active_duty <= '0;
            active_mode <= '0;
            pending     <= 1'b0;
            blink_cnt   <= '0;
            env         <= '0;
            br_state    <= ST_UP;
        end else begin
            if (load) begin
                shadow_duty <= duty_in;
                shadow_mode <= mode;
            end
            if (boundary) begin
                pending   <= 1'b0;
                blink_cnt <= blink_cnt + (BLINK_LOG2 + 1)'(1);
                if (apply) begin
                    active_duty <= load ? duty_in : shadow_duty;
                    active_mode <= new_mode;
                end
                if (new_mode == MODE_BREATHE && active_mode != MODE_BREATHE) begin
                    env      <= '0;
                    br_state <= ST_UP;
                end else if (active_mode == MODE_BREATHE) begin
                    if (br_state == ST_UP) begin
                        env <= env + PWM_W'(1);
                        if (env == ENV_TOP_M1) begin
                            br_state <= ST_DOWN;
                        end
                    end else begin
                        env <= env - PWM_W'(1);
                        if (env == ENV_ONE) begin
                            br_state <= ST_UP;
                        end
                    end
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [PWM_W-1:0] duty_i;
        logic [PWM_W-1:0] br_d;
        logic [PWM_W-1:0] d_mode;
        logic [PWM_W-1:0] d_eff;

        assign duty_i = active_duty[i*PWM_W +: PWM_W];
        assign br_d   = PWM_W'(({{PWM_W{1'b0}}, duty_i} * {{PWM_W{1'b0}}, env}) >> PWM_W);

        always_comb begin
            d_mode = duty_i;
            case (active_mode)
                MODE_BLINK:   d_mode = blink_on ? duty_i : '0;
                MODE_BREATHE: d_mode = br_d;
                default:      d_mode = duty_i;
            endcase
        end

`ifdef RGB_GAMMA_EN
        assign d_eff = PWM_W'(({{PWM_W{1'b0}}, d_mode} * {{PWM_W{1'b0}}, d_mode}) >> PWM_W);
`else
        assign d_eff = d_mode;
`endif

        assign led_next[i] = (pwm_cnt < d_eff);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led          <= '0;
            period_start <= 1'b0;
        end else begin
            led          <= led_next;
            period_start <= boundary;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb/tb_rgb_pwm_driver.sv - directed bench for rgb_pwm_driver (PWM_W=4, PRESC=2, NCH=3).
module tb_rgb_pwm_driver;

    localparam int NCH        = 3;
    localparam int PWM_W      = 4;
    localparam int PRESC      = 2;
    localparam int BLINK_LOG2 = 1;
    localparam int CNT_W      = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] duty_in = 12'd0;
    logic        load = 1'b0;
    logic [2:0]  led;
    logic        period_start;

    int errors = 0;
    int checks = 0;
    int nps    = 0;

    always #5 clk = ~clk;

    rgb_pwm_driver #(
        .NCH(NCH), .PWM_W(PWM_W), .PRESC(PRESC), .BLINK_LOG2(BLINK_LOG2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .duty_in(duty_in), .load(load),
        .led(led), .period_start(period_start)
    );

    // Boundaries since reset; blink phase is bit BLINK_LOG2 of this count.
    always @(negedge clk or negedge rst) begin
        if (!rst) nps <= 0;
        else if (period_start) nps <= nps + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int eff(input int d);
`ifdef RGB_GAMMA_EN
        return (d * d) >> 4;
`else
        return d;
`endif
    endfunction

    task automatic do_load(input logic [11:0] d, input logic [1:0] m);
        duty_in = d;
        mode    = m;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_ps();
        int n = 0;
        while (period_start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_ps", int'(period_start === 1'b1), 1);
    endtask

    // Starts on a period_start sample, ends on the next one; optional load at sample k.
    task automatic measure(input string tag, input int load_at, input logic [11:0] ld_d,
                           input logic [1:0] ld_m, input int e0, input int e1, input int e2,
                           input bit blink, output bit on);
        int c0 = 0, c1 = 0, c2 = 0, psmid = 0, psend = 0;
        on = 1'b1;
        for (int k = 0; k < 32; k++) begin
            if (k == load_at) begin
                duty_in = ld_d;
                mode    = ld_m;
                load    = 1'b1;
            end
            @(negedge clk);
            load = 1'b0;
            c0 += int'(led[0]);
            c1 += int'(led[1]);
            c2 += int'(led[2]);
            if (k == 15 && blink) on = nps[BLINK_LOG2];
            if (k < 31) psmid += int'(period_start);
            else psend = int'(period_start);
        end
        check({tag, "_led0"}, c0, on ? e0 : 0);
        check({tag, "_led1"}, c1, on ? e1 : 0);
        check({tag, "_led2"}, c2, on ? e2 : 0);
        check({tag, "_ps_mid"}, psmid, 0);
        check({tag, "_ps_end"}, psend, 1);
    endtask

    initial begin
        bit on;
        int on_cnt;
        int n;

        repeat (3) @(negedge clk);
        check("rst_led", int'(led), 0);
        check("rst_ps", int'(period_start), 0);
        check("rst_count", int'(dut.count), 0);
        rst = 1'b1;

        do_load(12'h084, 2'd0);
        wait_ps();
        measure("static", -1, 12'h000, 2'd0, 2*eff(4), 2*eff(8), 0, 1'b0, on);

        measure("ld15", 5, 12'h00F, 2'd0, 2*eff(4), 2*eff(8), 0, 1'b0, on);
        measure("d15", 5, 12'h000, 2'd0, 2*eff(15), 0, 0, 1'b0, on);
        measure("d0", 5, 12'h004, 2'd0, 0, 0, 0, 1'b0, on);

        measure("mid_old", 10, 12'h00C, 2'd0, 2*eff(4), 0, 0, 1'b0, on);
        measure("mid_new", -1, 12'h000, 2'd0, 2*eff(12), 0, 0, 1'b0, on);
        measure("bnd_old", 31, 12'h008, 2'd0, 2*eff(12), 0, 0, 1'b0, on);
        measure("bnd_new", -1, 12'h000, 2'd0, 2*eff(8), 0, 0, 1'b0, on);

        measure("br_ld", 5, 12'h00F, 2'd2, 2*eff(8), 0, 0, 1'b0, on);
        for (int e = 0; e <= 15; e++)
            measure($sformatf("br_up%0d", e), -1, 12'h000, 2'd0,
                    2*eff((15*e) >> 4), 0, 0, 1'b0, on);
        for (int e = 14; e >= 13; e--)
            measure($sformatf("br_dn%0d", e), -1, 12'h000, 2'd0,
                    2*eff((15*e) >> 4), 0, 0, 1'b0, on);

        measure("bl_ld", 5, 12'h008, 2'd1, 2*eff((15*12) >> 4), 0, 0, 1'b0, on);
        on_cnt = 0;
        for (int p = 0; p < 4; p++) begin
            measure($sformatf("blink%0d", p), -1, 12'h000, 2'd0, 2*eff(8), 0, 0, 1'b1, on);
            on_cnt += int'(on);
        end
        check("blink_on_periods", on_cnt, 2);

        n = 0;
        while (led[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pulse_seen", int'(led[0] === 1'b1), 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_led", int'(led), 0);
        check("async_count", int'(dut.count), 0);
        check("async_ps", int'(period_start), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (1000) @(negedge clk);
        check("count_1000", int'(dut.count), 1000);
        wait_ps();
        measure("post_rst", -1, 12'h000, 2'd0, 0, 0, 0, 1'b0, on);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
